// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared ALU: registers the winner's operation,
// drives exactly one bus enable for a single EXEC cycle and latches the compare flags.
module alu_arbiter #(
    parameter int WIDTH       = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [3:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_bus_en,
    output logic             alu_addr_en,
    input  logic             alu_eq,
    input  logic             alu_lt,
    input  logic             alu_ge,
    output logic             cmp_eq,
    output logic             cmp_lt,
    output logic             cmp_ge
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd6;

    state_t           state_q,   state_d;
    logic             prio_q,    prio_d;
    logic             owner_q,   owner_d;
    logic             gnt0_q,    gnt0_d;
    logic             gnt1_q,    gnt1_d;
    logic             err_q,     err_d;
    logic             bus_en_q,  bus_en_d;
    logic             addr_en_q, addr_en_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [3:0]       alu_op_q,  alu_op_d;
    logic             cmp_eq_q,  cmp_eq_d;
    logic             cmp_lt_q,  cmp_lt_d;
    logic             cmp_ge_q,  cmp_ge_d;

    logic in_exec;
    logic req0_ok;
    logic req1_ok;
    logic win0;
    logic win1;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d   = IDLE;
        prio_d    = prio_q;
        owner_d   = owner_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        err_d     = 1'b0;
        bus_en_d  = 1'b0;
        addr_en_d = 1'b0;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        cmp_eq_d  = cmp_eq_q;
        cmp_lt_d  = cmp_lt_q;
        cmp_ge_d  = cmp_ge_q;

        in_exec = (state_q == EXEC);

        // The request already being executed is consumed by its grant.
        req0_ok = req0 && !(in_exec && !owner_q);
        req1_ok = req1 && !(in_exec &&  owner_q);

        if (ROUND_ROBIN) begin
            win0 = req0_ok && (!req1_ok || !prio_q);
            win1 = req1_ok && (!req0_ok ||  prio_q);
        end else begin
            // Fixed priority: a pending execute request, even while masked, keeps
            // the address path waiting.
            win0 = req0_ok;
            win1 = req1_ok && !req0;
        end

        if (in_exec) begin
            cmp_eq_d = alu_eq;
            cmp_lt_d = alu_lt;
            cmp_ge_d = alu_ge;
            prio_d   = !owner_q;
        end

        if (win0) begin
            state_d   = EXEC;
            owner_d   = 1'b0;
            alu_op_d  = op0;
            alu_a_d   = a0;
            alu_b_d   = b0;
            gnt0_d    = 1'b1;
            err_d     = !op_legal(op0);
            bus_en_d  = op_legal(op0);
        end else if (win1) begin
            state_d   = EXEC;
            owner_d   = 1'b1;
            alu_op_d  = op1;
            alu_a_d   = a1;
            alu_b_d   = b1;
            gnt1_d    = 1'b1;
            err_d     = !op_legal(op1);
            addr_en_d = op_legal(op1);
        end
    end

    // Async reset clears every strobe at once, aborting an EXEC in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            owner_q   <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            err_q     <= 1'b0;
            bus_en_q  <= 1'b0;
            addr_en_q <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            cmp_eq_q  <= 1'b0;
            cmp_lt_q  <= 1'b0;
            cmp_ge_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q   <= state_d;
            prio_q    <= prio_d;
            owner_q   <= owner_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            err_q     <= err_d;
            bus_en_q  <= bus_en_d;
            addr_en_q <= addr_en_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            cmp_eq_q  <= cmp_eq_d;
            cmp_lt_q  <= cmp_lt_d;
            cmp_ge_q  <= cmp_ge_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign err         = err_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_bus_en  = bus_en_q;
    assign alu_addr_en = addr_en_q;
    assign cmp_eq      = cmp_eq_q;
    assign cmp_lt      = cmp_lt_q;
    assign cmp_ge      = cmp_ge_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random checks for alu_arbiter: one round-robin instance and one
// fixed-priority instance share the same requester stimulus.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [3:0]   op0, op1;
    logic [W-1:0] a0, b0, a1, b1;

    logic         gnt0, gnt1, err, bus_en, addr_en, cmp_eq, cmp_lt, cmp_ge;
    logic [W-1:0] alu_a, alu_b;
    logic [3:0]   alu_op;
    logic         alu_eq, alu_lt, alu_ge;

    logic         f_gnt0, f_gnt1, f_err, f_bus_en, f_addr_en, f_cmp_eq, f_cmp_lt, f_cmp_ge;
    logic [W-1:0] f_alu_a, f_alu_b;
    logic [3:0]   f_alu_op;
    logic         f_alu_eq, f_alu_lt, f_alu_ge;

    logic [4:0]   st;
    logic [2:0]   cmp;
    logic [4:0]   f_st;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Behavioural ALU flags computed from the registered operands.
    assign alu_eq   = (alu_a == alu_b);
    assign alu_lt   = (alu_a <  alu_b);
    assign alu_ge   = (alu_a >= alu_b);
    assign f_alu_eq = (f_alu_a == f_alu_b);
    assign f_alu_lt = (f_alu_a <  f_alu_b);
    assign f_alu_ge = (f_alu_a >= f_alu_b);

    assign st   = {gnt0, gnt1, err, bus_en, addr_en};
    assign cmp  = {cmp_eq, cmp_lt, cmp_ge};
    assign f_st = {f_gnt0, f_gnt1, f_err, f_bus_en, f_addr_en};

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .err(err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_bus_en(bus_en), .alu_addr_en(addr_en),
        .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_ge(alu_ge),
        .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .cmp_ge(cmp_ge)
    );

    alu_arbiter #(.WIDTH(W), .ROUND_ROBIN(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .err(f_err),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op),
        .alu_bus_en(f_bus_en), .alu_addr_en(f_addr_en),
        .alu_eq(f_alu_eq), .alu_lt(f_alu_lt), .alu_ge(f_alu_ge),
        .cmp_eq(f_cmp_eq), .cmp_lt(f_cmp_lt), .cmp_ge(f_cmp_ge)
    );

    function automatic logic [W-1:0] alu_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'd0:    return a | b;
            4'd1:    return a ^ b;
            4'd2:    return a & b;
            4'd3:    return a << b[4:0];
            4'd4:    return a >> b[4:0];
            4'd5:    return a + b;
            4'd6:    return a - b;
            default: return '0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        @(negedge clk);
        checks++; if (st !== 5'b00000) $display("FAIL reset_strobes: got %b want %b", st, 5'b00000); else passes++;
        checks++; if (cmp !== 3'b000) $display("FAIL reset_cmp: got %b want %b", cmp, 3'b000); else passes++;
        checks++; if ({alu_op, alu_a, alu_b} !== 68'd0) $display("FAIL reset_alu_regs: got %h want 0", {alu_op, alu_a, alu_b}); else passes++;
        checks++; if (f_st !== 5'b00000) $display("FAIL reset_fix_strobes: got %b want %b", f_st, 5'b00000); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        req0 = 1'b1; op0 = 4'd5; a0 = 32'd3; b0 = 32'd4;
        @(negedge clk);
        checks++; if (st !== 5'b10010) $display("FAIL add_strobes: got %b want %b", st, 5'b10010); else passes++;
        checks++; if (alu_op !== 4'd5) $display("FAIL add_op: got %0d want 5", alu_op); else passes++;
        checks++; if ({alu_a, alu_b} !== {32'd3, 32'd4}) $display("FAIL add_operands: got %0d,%0d want 3,4", alu_a, alu_b); else passes++;
        checks++; if (alu_res(alu_op, alu_a, alu_b) !== 32'd7) $display("FAIL add_bus: got %0d want 7", alu_res(alu_op, alu_a, alu_b)); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (st !== 5'b00000) $display("FAIL add_release: got %b want %b", st, 5'b00000); else passes++;
        @(negedge clk);
        checks++; if (cmp !== 3'b010) $display("FAIL add_cmp: got %b want %b", cmp, 3'b010); else passes++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0 = 1'b1; op0 = 4'd5; a0 = 32'd1; b0 = 32'd2;
        req1 = 1'b1; op1 = 4'd0; a1 = 32'd8; b1 = 32'd1;
        @(negedge clk);
        checks++; if (st !== 5'b10010) $display("FAIL b2b_first: got %b want %b", st, 5'b10010); else passes++;
        checks++; if (alu_a !== 32'd1) $display("FAIL b2b_first_a: got %0d want 1", alu_a); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (st !== 5'b01001) $display("FAIL b2b_second: got %b want %b", st, 5'b01001); else passes++;
        checks++; if (alu_res(alu_op, alu_a, alu_b) !== 32'd9) $display("FAIL b2b_addr_bus: got %0d want 9", alu_res(alu_op, alu_a, alu_b)); else passes++;
        req1 = 1'b0;
        @(negedge clk);
        checks++; if (st !== 5'b00000) $display("FAIL b2b_idle: got %b want %b", st, 5'b00000); else passes++;
    endtask

    task automatic test_fixed_priority();
        int n0;
        n0 = 0;
        do_reset();
        req0 = 1'b1; op0 = 4'd5; a0 = 32'd2; b0 = 32'd2;
        req1 = 1'b1; op1 = 4'd1; a1 = 32'd6; b1 = 32'd3;
        repeat (8) begin
            @(negedge clk);
            checks++; if (f_gnt1 !== 1'b0) $display("FAIL fix_starve_gnt1: got %b want 0", f_gnt1); else passes++;
            if (f_gnt0) n0++;
        end
        checks++; if (n0 < 1) $display("FAIL fix_gnt0_served: got %0d grants want >=1", n0); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (f_st !== 5'b01001) $display("FAIL fix_gnt1_after_drop: got %b want %b", f_st, 5'b01001); else passes++;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_compare();
        do_reset();
        req1 = 1'b1; op1 = 4'd6; a1 = 32'd5; b1 = 32'd5;
        @(negedge clk);
        checks++; if (st !== 5'b01001) $display("FAIL sub_strobes: got %b want %b", st, 5'b01001); else passes++;
        checks++; if (alu_op !== 4'd6) $display("FAIL sub_op: got %0d want 6", alu_op); else passes++;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (cmp !== 3'b101) $display("FAIL sub_cmp: got %b want %b", cmp, 3'b101); else passes++;
        repeat (3) begin
            @(negedge clk);
            checks++; if (cmp !== 3'b101) $display("FAIL sub_cmp_hold: got %b want %b", cmp, 3'b101); else passes++;
        end
    endtask

    task automatic test_illegal();
        req0 = 1'b1; op0 = 4'd9; a0 = 32'd7; b0 = 32'd7;
        @(negedge clk);
        checks++; if (st !== 5'b10100) $display("FAIL illegal_strobes: got %b want %b", st, 5'b10100); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (st !== 5'b00000) $display("FAIL illegal_release: got %b want %b", st, 5'b00000); else passes++;
        req0 = 1'b1; op0 = 4'd2; a0 = 32'd12; b0 = 32'd10;
        @(negedge clk);
        checks++; if (st !== 5'b10010) $display("FAIL legal_after_err: got %b want %b", st, 5'b10010); else passes++;
        checks++; if (alu_res(alu_op, alu_a, alu_b) !== 32'd8) $display("FAIL and_bus: got %0d want 8", alu_res(alu_op, alu_a, alu_b)); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (cmp !== 3'b001) $display("FAIL and_cmp: got %b want %b", cmp, 3'b001); else passes++;
    endtask

    task automatic test_reset_mid_exec();
        req1 = 1'b1; op1 = 4'd5; a1 = 32'd1; b1 = 32'd1;
        @(negedge clk);
        checks++; if (st !== 5'b01001) $display("FAIL pre_abort_strobes: got %b want %b", st, 5'b01001); else passes++;
        rst = 1'b1; req1 = 1'b0;
        #1;
        checks++; if (st !== 5'b00000) $display("FAIL abort_strobes: got %b want %b", st, 5'b00000); else passes++;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (cmp !== 3'b000) $display("FAIL abort_cmp: got %b want %b", cmp, 3'b000); else passes++;
        req0 = 1'b1; op0 = 4'd0; a0 = 32'd4; b0 = 32'd1;
        req1 = 1'b1; op1 = 4'd1; a1 = 32'd4; b1 = 32'd1;
        @(negedge clk);
        checks++; if (st !== 5'b10010) $display("FAIL abort_prio0: got %b want %b", st, 5'b10010); else passes++;
        req0 = 1'b0;
        @(negedge clk);
        checks++; if (st !== 5'b01001) $display("FAIL abort_then_gnt1: got %b want %b", st, 5'b01001); else passes++;
        req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int age0, age1;
        age0 = 0; age1 = 0;
        do_reset();
        repeat (1000) begin
            @(negedge clk);
            checks++; if (bus_en && addr_en) $display("FAIL rand_both_en: got bus=%b addr=%b want not both", bus_en, addr_en); else passes++;
            if (req0) begin
                age0++;
                if (gnt0) begin
                    checks++; if (age0 > 2) $display("FAIL rand_lat0: got %0d cycles want <=2", age0); else passes++;
                    req0 = 1'b0;
                end else if (age0 > 2) begin
                    checks++; $display("FAIL rand_starve0: got no gnt0 after %0d cycles want <=2", age0);
                    req0 = 1'b0;
                end
            end else begin
                checks++; if (gnt0 !== 1'b0) $display("FAIL rand_spurious0: got gnt0=%b want 0", gnt0); else passes++;
                if ($urandom_range(0, 1) == 1) begin
                    req0 = 1'b1; age0 = 0; op0 = 4'($urandom_range(0, 6)); a0 = $urandom; b0 = $urandom;
                end
            end
            if (req1) begin
                age1++;
                if (gnt1) begin
                    checks++; if (age1 > 2) $display("FAIL rand_lat1: got %0d cycles want <=2", age1); else passes++;
                    req1 = 1'b0;
                end else if (age1 > 2) begin
                    checks++; $display("FAIL rand_starve1: got no gnt1 after %0d cycles want <=2", age1);
                    req1 = 1'b0;
                end
            end else begin
                checks++; if (gnt1 !== 1'b0) $display("FAIL rand_spurious1: got gnt1=%b want 0", gnt1); else passes++;
                if ($urandom_range(0, 1) == 1) begin
                    req1 = 1'b1; age1 = 0; op1 = 4'($urandom_range(0, 6)); a1 = $urandom; b1 = $urandom;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_fixed_priority();
        test_compare();
        test_illegal();
        test_reset_mid_exec();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
